// File: rtl/iqmap_bpsk.sv
// BPSK bit mapper: 128-bit words in, one antipodal I/Q symbol per ce cycle.
// Hold register plus shift register give gap-free back-to-back streaming.
module iqmap_bpsk (
  input  logic               ck,
  input  logic               rst,
  input  logic               ce,
  input  logic               valid_i,
  input  logic [127:0]       data_i,
  output logic               ready_o,
  output logic               valid_o,
  output logic signed [10:0] ar,
  output logic signed [10:0] ai,
  output logic               bit_o,
  output logic               last_o
);

  typedef enum logic {
    IDLE,
    SEND
  } state_e;

  localparam logic signed [10:0] AR_POS = 11'sh3FF;
  localparam logic signed [10:0] AR_NEG = 11'sh400;
  localparam logic [6:0]         CNT_LAST = 7'd127;

  state_e             state_q, state_d;
  logic [127:0]       hold_q, hold_d;
  logic               hold_full_q, hold_full_d;
  logic [127:0]       shift_q, shift_d;
  logic [6:0]         cnt_q, cnt_d;
  logic               valid_q, valid_d;
  logic               bit_q, bit_d;
  logic               last_q, last_d;
  logic signed [10:0] ar_q, ar_d;

  logic accept;
  logic load;
  logic emit;

  assign ready_o = ~hold_full_q;
  assign accept  = valid_i & ~hold_full_q & ce;

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    valid_d     = valid_q;
    bit_d       = bit_q;
    last_d      = last_q;
    ar_d        = ar_q;
    load        = 1'b0;
    emit        = 1'b0;

    if (ce) begin
      unique case (state_q)
        IDLE: begin
          if (hold_full_q) begin
            load    = 1'b1;
            state_d = SEND;
          end
        end
        SEND: begin
          emit = 1'b1;
          if (cnt_q == CNT_LAST) begin
            if (hold_full_q) begin
              load = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase

      valid_d = emit;
      bit_d   = emit & shift_q[0];
      last_d  = emit & (cnt_q == CNT_LAST);
      if (!emit) begin
        ar_d = '0;
      end else if (shift_q[0]) begin
        ar_d = AR_POS;
      end else begin
        ar_d = AR_NEG;
      end

      if (emit) begin
        shift_d = shift_q >> 1;
        cnt_d   = cnt_q + 7'd1;
      end
      // A reload on the final bit keeps the symbol stream contiguous.
      if (load) begin
        shift_d     = hold_q;
        cnt_d       = '0;
        hold_full_d = 1'b0;
      end
      if (accept) begin
        hold_d      = data_i;
        hold_full_d = 1'b1;
      end
    end
  end

  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      cnt_q       <= '0;
      valid_q     <= 1'b0;
      bit_q       <= 1'b0;
      last_q      <= 1'b0;
      ar_q        <= '0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      valid_q     <= valid_d;
      bit_q       <= bit_d;
      last_q      <= last_d;
      ar_q        <= ar_d;
    end
  end

  assign valid_o = valid_q;
  assign bit_o   = bit_q;
  assign last_o  = last_q;
  assign ar      = ar_q;
  assign ai      = '0;

endmodule

// File: tb/tb_iqmap_bpsk.sv
// Bench for iqmap_bpsk: directed steps with random words, checked
// against a queue of expected bits built from every accepted word.
module tb_iqmap_bpsk;

  logic               ck = 1'b0;
  logic               rst = 1'b0;
  logic               ce = 1'b0;
  logic               valid_i = 1'b0;
  logic [127:0]       data_i = '0;
  logic               ready_o;
  logic               valid_o;
  logic signed [10:0] ar;
  logic signed [10:0] ai;
  logic               bit_o;
  logic               last_o;

  int total = 0;
  int bad = 0;

  iqmap_bpsk dut (
    .ck      (ck),
    .rst     (rst),
    .ce      (ce),
    .valid_i (valid_i),
    .data_i  (data_i),
    .ready_o (ready_o),
    .valid_o (valid_o),
    .ar      (ar),
    .ai      (ai),
    .bit_o   (bit_o),
    .last_o  (last_o)
  );

  always #5 ck = ~ck;

  task automatic chk(input string tag,
                     input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: each entry is bit_index*2 + bit value, in air order.
  int   mq[$];
  logic ce_s = 1'b0;
  int   ev = 0;
  int   eb = 0;
  int   el = 0;
  int   ea = 0;

  always @(negedge ck) begin
    int e;
    if (!rst) begin
      chk("rst_valid", valid_o, 0);
      chk("rst_ar", ar, 0);
      chk("rst_ai", ai, 0);
      chk("rst_bit", bit_o, 0);
      chk("rst_last", last_o, 0);
      chk("rst_ready", ready_o, 1);
      mq.delete();
      ev = 0; eb = 0; el = 0; ea = 0;
    end else if (!ce_s) begin
      chk("hold_valid", valid_o, ev);
      chk("hold_ar", ar, ea);
      chk("hold_bit", bit_o, eb);
      chk("hold_last", last_o, el);
    end else if (valid_o) begin
      if (mq.size() == 0) begin
        chk("spurious_sym", valid_o, 0);
      end else begin
        e  = mq.pop_front();
        ev = 1;
        eb = e % 2;
        el = ((e / 2) == 127) ? 1 : 0;
        ea = (eb == 1) ? 1023 : -1024;
        chk("sym_bit", bit_o, eb);
        chk("sym_ar", ar, ea);
        chk("sym_ai", ai, 0);
        chk("sym_last", last_o, el);
      end
    end else begin
      ev = 0; eb = 0; el = 0; ea = 0;
      chk("idle_ar", ar, 0);
      chk("idle_ai", ai, 0);
      chk("idle_bit", bit_o, 0);
      chk("idle_last", last_o, 0);
    end
    ce_s = ce;
    if (rst && ce && valid_i && ready_o) begin
      for (int i = 0; i < 128; i++) begin
        mq.push_back(i * 2 + int'(data_i[i]));
      end
    end
  end

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic send(input logic [127:0] d);
    bit ok;
    ok = 1'b0;
    valid_i = 1'b1;
    data_i  = d;
    for (int k = 0; k < 2000 && !ok; k++) begin
      @(negedge ck);
      if (ready_o && ce) ok = 1'b1;
      @(posedge ck);
      #1;
    end
    valid_i = 1'b0;
    if (!ok) chk("send_timeout", ready_o, 1);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!valid_o && lat < 50) begin
      @(posedge ck);
      #1;
      lat++;
    end
    if (!valid_o) chk("valid_timeout", valid_o, 1);
  endtask

  task automatic run_len(output int n, output int lastpos);
    int w;
    wait_valid(w);
    n = 0;
    lastpos = -1;
    while (valid_o && n < 1000) begin
      n++;
      if (last_o && lastpos < 0) lastpos = n;
      @(posedge ck);
      #1;
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 2000 && (mq.size() != 0 || valid_o); k++) begin
      @(posedge ck);
      #1;
    end
    chk("drain_q", mq.size(), 0);
  endtask

  initial begin
    int lat;
    int n;
    int lp;
    logic cur;
    logic acc_now;
    logic saw_stall;
    logic [127:0] w;

    ce = 1'b1;
    rst = 1'b0;
    repeat (2) @(posedge ck);
    chk("rst_in_valid", valid_o, 0);
    chk("rst_in_ready", ready_o, 1);
    #1 rst = 1'b1;
    @(posedge ck);
    #1;
    chk("post_rst_valid", valid_o, 0);
    chk("post_rst_ar", ar, 0);
    chk("post_rst_ready", ready_o, 1);

    send(128'h1);
    wait_valid(lat);
    chk("latency", lat, 2);
    chk("first_ar", ar, 1023);
    chk("first_bit", bit_o, 1);
    run_len(n, lp);
    chk("len_single", n, 128);
    chk("last_single", lp, 128);
    chk("idle_after", valid_o, 0);

    send({128{1'b1}});
    send('0);
    run_len(n, lp);
    chk("len_b2b", n, 256);
    chk("last_b2b", lp, 128);

    ce = 1'b1;
    send(rnd128());
    n = 0;
    for (int i = 0; i < 800; i++) begin
      cur = ce;
      @(posedge ck);
      #1;
      if (cur && valid_o) n++;
      ce = ~ce;
    end
    ce = 1'b1;
    chk("ce_syms", n, 128);
    drain();

    saw_stall = 1'b0;
    valid_i = 1'b1;
    data_i  = rnd128();
    for (int i = 0; i < 700; i++) begin
      @(negedge ck);
      acc_now = ready_o;
      if (!ready_o) saw_stall = 1'b1;
      @(posedge ck);
      #1;
      if (acc_now) data_i = rnd128();
    end
    valid_i = 1'b0;
    chk("stall_seen", saw_stall, 1);
    drain();

    send(rnd128());
    wait_valid(lat);
    repeat (60) begin
      @(posedge ck);
      #1;
    end
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", valid_o, 0);
    chk("mid_rst_ar", ar, 0);
    chk("mid_rst_ready", ready_o, 1);
    repeat (2) @(posedge ck);
    #1 rst = 1'b1;
    w = rnd128();
    send(w);
    wait_valid(lat);
    chk("new_lat", lat, 2);
    chk("new_first_bit", bit_o, w[0]);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
